xor2_arc_sequencer: RTL and testbench

- On-chip stimulus/check controller for a gp12t3v3 xor2 device-under-test (DUT) instance.
- Sequences the DUT's A/B inputs through all four conditional timing arcs (A with B=0/1, B with A=0/1), rising and falling.
- Holds each vector for a programmable settle time, samples Y and counts mismatches against A^B.
- Used in the library test-chip ring/delay harness to qualify xor2 cells after layout changes.

---
 rtl/xor2_arc_sequencer.sv | 120 ++++++++++++
 tb/tb_xor2_arc_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/xor2_arc_sequencer.sv
// Stimulus/check sequencer for an xor2 cell: walks all four conditional arcs,
// holds each vector SETTLE+1 cycles, samples Y and counts mismatches vs A^B.
module xor2_arc_sequencer #(
  parameter int SETTLE_W = 4,
  parameter int LOOPS_W  = 8,
  parameter int ERR_W    = 8
) (
  input  logic                CLK,
  input  logic                RN,
  input  logic                START,
  input  logic [SETTLE_W-1:0] SETTLE,
  input  logic [LOOPS_W-1:0]  LOOPS,
  input  logic                DUT_Y,
  output logic                DUT_A,
  output logic                DUT_B,
  output logic [1:0]          ARC,
  output logic                BUSY,
  output logic                DONE,
  output logic                PASS,
  output logic [ERR_W-1:0]    ERR_CNT
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] INIT  = 2'd1;
  localparam logic [1:0] APPLY = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  logic [1:0]          state;
  logic [SETTLE_W-1:0] settle_r, cnt;
  logic [LOOPS_W-1:0]  loops_r, loop;
  logic [2:0]          step;
  logic                mismatch;
  logic [ERR_W-1:0]    err_nxt;

  // {A,B} per step; pairs of steps toggle one input with the other held
  function automatic logic [1:0] vec(input logic [2:0] s);
    case (s)
      3'd0: vec = 2'b10;
      3'd1: vec = 2'b00;
      3'd2: vec = 2'b11;
      3'd3: vec = 2'b01;
      3'd4: vec = 2'b01;
      3'd5: vec = 2'b00;
      3'd6: vec = 2'b11;
      default: vec = 2'b10;
    endcase
  endfunction

  always_comb begin
    mismatch = DUT_Y != (^vec(step));
    err_nxt  = ERR_CNT;
    if (mismatch && ERR_CNT != '1) err_nxt = ERR_CNT + 1'b1;
  end

  assign BUSY = (state == INIT) || (state == APPLY);
  assign DONE = (state == FIN);
  assign ARC  = (state == APPLY) ? step[2:1] : 2'b00;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state    <= IDLE;
      settle_r <= '0;
      loops_r  <= '0;
      cnt      <= '0;
      loop     <= '0;
      step     <= '0;
      DUT_A    <= 1'b0;
      DUT_B    <= 1'b0;
      PASS     <= 1'b0;
      ERR_CNT  <= '0;
    end else begin
      case (state)
        IDLE: if (START) begin
          ERR_CNT <= '0;
          if (LOOPS != '0) begin
            settle_r <= SETTLE;
            loops_r  <= LOOPS;
            cnt      <= SETTLE;
            PASS     <= 1'b0;
            state    <= INIT;
          end else begin
            PASS  <= 1'b1;
            state <= FIN;
          end
        end
        INIT: begin
          if (cnt == '0) begin
            state          <= APPLY;
            step           <= 3'd0;
            loop           <= '0;
            cnt            <= settle_r;
            {DUT_A, DUT_B} <= vec(3'd0);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        APPLY: begin
          if (cnt == '0) begin
            ERR_CNT <= err_nxt;
            if (step == 3'd7 && loop == loops_r - 1'b1) begin
              state          <= FIN;
              PASS           <= (err_nxt == '0);
              step           <= 3'd0;
              {DUT_A, DUT_B} <= 2'b00;
            end else begin
              step           <= step + 3'd1;
              cnt            <= settle_r;
              {DUT_A, DUT_B} <= vec(step + 3'd1);
              if (step == 3'd7) loop <= loop + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor2_arc_sequencer.sv
// Directed table-driven bench for xor2_arc_sequencer with a behavioural DUT_Y
// model (ideal / stuck-at / inverted) and a cycle-accurate vector schedule.
module tb_xor2_arc_sequencer;

  logic       CLK = 0, RN = 0, START = 0, DUT_Y;
  logic [3:0] SETTLE = 0;
  logic [7:0] LOOPS = 0;
  logic       DUT_A, DUT_B, BUSY, DONE, PASS;
  logic [1:0] ARC;
  logic [7:0] ERR_CNT;

  // 0 ideal xor, 1 stuck-at-0, 2 xnor, 3 stuck-at-1
  int ymode = 0;
  int errors = 0, checks = 0;

  xor2_arc_sequencer #(.SETTLE_W(4), .LOOPS_W(8), .ERR_W(8)) dut (
    .CLK(CLK), .RN(RN), .START(START), .SETTLE(SETTLE), .LOOPS(LOOPS),
    .DUT_Y(DUT_Y), .DUT_A(DUT_A), .DUT_B(DUT_B), .ARC(ARC), .BUSY(BUSY),
    .DONE(DONE), .PASS(PASS), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    case (ymode)
      0: DUT_Y = DUT_A ^ DUT_B;
      1: DUT_Y = 1'b0;
      2: DUT_Y = ~(DUT_A ^ DUT_B);
      default: DUT_Y = 1'b1;
    endcase
  end

  typedef struct {
    int settle; int loops; int mode; bit repulse;
    int exp_err; bit exp_pass; int exp_cyc;
  } vec_t;

  logic [1:0] vtab [8];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int c, ix;
    bit seen;
    c = 0; seen = 0;
    @(negedge CLK);
    SETTLE = v.settle[3:0]; LOOPS = v.loops[7:0]; ymode = v.mode; START = 1;
    while (!seen && c < 5000) begin
      @(posedge CLK); #1;
      c++;
      if (c == 1 && !v.repulse) START = 0;
      if (v.repulse && c == 1) begin START = 0; SETTLE = 4'd9; LOOPS = 8'd7; end
      if (v.repulse && c == 5) START = 1;
      if (v.repulse && c == 6) START = 0;
      if (DONE && BUSY) chk($sformatf("v%0d done_and_busy c%0d", idx, c), 1, 0);
      if (v.loops == 0 && BUSY) chk($sformatf("v%0d busy_loops0", idx), 1, 0);
      if (DONE) seen = 1;
      else if (c <= v.settle + 1) begin
        chk($sformatf("v%0d init_ab c%0d", idx, c), {DUT_A, DUT_B}, 0);
        chk($sformatf("v%0d init_arc c%0d", idx, c), ARC, 0);
      end else begin
        ix = ((c - (v.settle + 2)) / (v.settle + 1)) % 8;
        chk($sformatf("v%0d ab c%0d", idx, c), {DUT_A, DUT_B}, vtab[ix]);
        chk($sformatf("v%0d arc c%0d", idx, c), ARC, ix / 2);
      end
    end
    chk($sformatf("v%0d done_seen", idx), seen, 1);
    chk($sformatf("v%0d done_latency", idx), c, v.exp_cyc);
    chk($sformatf("v%0d err_cnt", idx), ERR_CNT, v.exp_err);
    chk($sformatf("v%0d pass", idx), PASS, v.exp_pass);
    chk($sformatf("v%0d fin_ab", idx), {DUT_A, DUT_B}, 0);
    @(posedge CLK); #1;
    chk($sformatf("v%0d done_pulse", idx), DONE, 0);
    chk($sformatf("v%0d idle_busy", idx), BUSY, 0);
    chk($sformatf("v%0d err_held", idx), ERR_CNT, v.exp_err);
    chk($sformatf("v%0d pass_held", idx), PASS, v.exp_pass);
  endtask

  initial begin
    vec_t tv [6];
    bit dseen;
    vtab[0] = 2'b10; vtab[1] = 2'b00; vtab[2] = 2'b11; vtab[3] = 2'b01;
    vtab[4] = 2'b01; vtab[5] = 2'b00; vtab[6] = 2'b11; vtab[7] = 2'b10;
    //        settle loops mode rep err pass cyc
    tv[0] = '{0,  1, 0, 0,   0, 1,  10};
    tv[1] = '{3,  3, 1, 0,  12, 0, 101};
    tv[2] = '{0, 40, 2, 0, 255, 0, 322};
    tv[3] = '{5,  0, 1, 0,   0, 1,   1};
    tv[4] = '{1,  2, 0, 1,   0, 1,  35};
    tv[5] = '{2,  1, 3, 0,   4, 0,  28};

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ab", {DUT_A, DUT_B}, 0);
    chk("rst_flags", {BUSY, DONE, PASS}, 0);
    chk("rst_err", ERR_CNT, 0);
    chk("rst_arc", ARC, 0);
    @(negedge CLK); RN = 1;

    for (int i = 0; i < 6; i++) run(tv[i], i);

    // Abort at loop 1 step 5 with stuck-at-0 Y: 7 mismatches so far
    @(negedge CLK);
    SETTLE = 0; LOOPS = 2; ymode = 1; START = 1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge CLK); #1;
      START = 0;
    end
    chk("abort_pre_busy", BUSY, 1);
    chk("abort_pre_arc", ARC, 2);
    chk("abort_pre_err", ERR_CNT, 7);
    RN = 0; #1;
    chk("abort_ab", {DUT_A, DUT_B}, 0);
    chk("abort_flags", {BUSY, DONE, PASS, ARC}, 0);
    chk("abort_err", ERR_CNT, 0);
    dseen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      if (DONE) dseen = 1;
    end
    @(negedge CLK); RN = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) dseen = 1;
    end
    chk("abort_no_done", dseen, 0);
    run(tv[0], 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
